// File: rtl/bidir_pin_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bidir_pin_ctrl_if
// Description : Pad-side signal bundle for bidir_pin_ctrl.
//               The master side drives the requests and the raw pad input.
//               The slave side returns the pad enables and the conditioned input.
// Revision    : 1.0
// ============================================================================
interface bidir_pin_ctrl_if;
    logic dir_req;
    logic dout;
    logic pin_i;
    logic pin_oe;
    logic pin_o;
    logic din;
    logic din_rise;
    logic din_fall;
    logic busy;
    logic collision;

    modport master (
        output dir_req, dout, pin_i,
        input  pin_oe, pin_o, din, din_rise, din_fall, busy, collision
    );

    modport slave (
        input  dir_req, dout, pin_i,
        output pin_oe, pin_o, din, din_rise, din_fall, busy, collision
    );
endinterface
`default_nettype wire

// File: rtl/bidir_pin_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bidir_pin_ctrl
// Description : Direction arbiter and input conditioner for one bidirectional pad.
//               It inserts a tri-state turnaround on every direction change.
//               It also synchronises and debounces the pad input and produces edge pulses.
//               Optional pad-contention detection is enabled by COLLISION_DETECT_EN.
// Revision    : 1.0
// ============================================================================
module bidir_pin_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 48000,
    parameter int TURN_CYCLES     = 4
) (
    input  logic             clk48,
    input  logic             rst_n,
    bidir_pin_ctrl_if.slave  bus
);

    localparam int TURN_W = $clog2(TURN_CYCLES + 1);
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] S_IN     = 2'd0;
    localparam logic [1:0] S_TO_OUT = 2'd1;
    localparam logic [1:0] S_OUT    = 2'd2;
    localparam logic [1:0] S_TO_IN  = 2'd3;

    logic [SYNC_STAGES-1:0] r_dir_sync;
    logic [SYNC_STAGES-1:0] r_pin_sync;
    logic                   w_dir_s;
    logic                   w_pin_s;

    logic [1:0]             r_state;
    logic [1:0]             w_nxt;
    logic [TURN_W-1:0]      r_turn_cnt;
    logic [TURN_W-1:0]      w_turn_nxt;
    logic                   w_turn_done;

    logic                   r_pin_oe;
    logic                   r_pin_o;

    logic [DB_W-1:0]        r_db_cnt;
    logic                   r_din;
    logic                   r_din_rise;
    logic                   r_din_fall;

    logic                   w_trip;
    logic                   w_coll_hold;

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            r_dir_sync <= '0;
            r_pin_sync <= '0;
        end else begin
            r_dir_sync <= {r_dir_sync[SYNC_STAGES-2:0], bus.dir_req};
            r_pin_sync <= {r_pin_sync[SYNC_STAGES-2:0], bus.pin_i};
        end
    end

    assign w_dir_s     = r_dir_sync[SYNC_STAGES-1];
    assign w_pin_s     = r_pin_sync[SYNC_STAGES-1];
    assign w_turn_done = (r_turn_cnt == TURN_W'(TURN_CYCLES - 1));

    always_comb begin
        w_nxt      = r_state;
        w_turn_nxt = r_turn_cnt;
        case (r_state)
            S_IN: begin
                if (w_dir_s && !w_coll_hold) begin
                    w_nxt      = S_TO_OUT;
                    w_turn_nxt = '0;
                end
            end
            S_TO_OUT: begin
                if (!w_dir_s) begin
                    w_nxt = S_IN;
                end else if (w_turn_done) begin
                    w_nxt = S_OUT;
                end else begin
                    w_turn_nxt = r_turn_cnt + TURN_W'(1);
                end
            end
            S_OUT: begin
                if (!w_dir_s || w_trip) begin
                    w_nxt      = S_TO_IN;
                    w_turn_nxt = '0;
                end
            end
            S_TO_IN: begin
                // The return turnaround always completes so the pad is released for the full gap.
                if (w_turn_done) begin
                    w_nxt = S_IN;
                end else begin
                    w_turn_nxt = r_turn_cnt + TURN_W'(1);
                end
            end
            default: begin
                w_nxt      = S_IN;
                w_turn_nxt = '0;
            end
        endcase
    end

    // The pad controls are registered from the next state, so pin_oe and pin_o change on the edge the state changes.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IN;
            r_turn_cnt <= '0;
            r_pin_oe   <= 1'b0;
            r_pin_o    <= 1'b0;
        end else begin
            r_state    <= w_nxt;
            r_turn_cnt <= w_turn_nxt;
            r_pin_oe   <= (w_nxt == S_OUT);
            r_pin_o    <= (w_nxt == S_OUT) ? bus.dout : 1'b0;
        end
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt   <= '0;
            r_din      <= 1'b0;
            r_din_rise <= 1'b0;
            r_din_fall <= 1'b0;
        end else begin
            r_din_rise <= 1'b0;
            r_din_fall <= 1'b0;
            if (r_state != S_IN) begin
                r_db_cnt <= '0;
            end else if (w_pin_s == r_din) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_db_cnt   <= '0;
                r_din      <= w_pin_s;
                r_din_rise <= w_pin_s;
                r_din_fall <= !w_pin_s;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

`ifdef COLLISION_DETECT_EN
    localparam int CHK_W = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_po_dly;
    logic [CHK_W-1:0]       r_chk_cnt;
    logic                   r_mis;
    logic                   r_collision;
    logic                   w_cmp_en;
    logic                   w_mis;

    // The delayed pin_o and pin_s both reflect the same pin_o sample when the pad loops back cleanly.
    assign w_cmp_en    = (r_state == S_OUT) && (r_chk_cnt == CHK_W'(SYNC_STAGES));
    assign w_mis       = w_cmp_en && (w_pin_s != r_po_dly[SYNC_STAGES-1]);
    assign w_trip      = w_mis && r_mis;
    assign w_coll_hold = r_collision;

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            r_po_dly    <= '0;
            r_chk_cnt   <= '0;
            r_mis       <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_po_dly <= {r_po_dly[SYNC_STAGES-2:0], r_pin_o};
            r_mis    <= w_mis;
            if (r_state != S_OUT) begin
                r_chk_cnt <= '0;
            end else if (r_chk_cnt != CHK_W'(SYNC_STAGES)) begin
                r_chk_cnt <= r_chk_cnt + CHK_W'(1);
            end
            if (w_trip) begin
                r_collision <= 1'b1;
            end else if ((r_state == S_IN) && !w_dir_s) begin
                r_collision <= 1'b0;
            end
        end
    end

    assign bus.collision = r_collision;
`else
    assign w_trip        = 1'b0;
    assign w_coll_hold   = 1'b0;
    assign bus.collision = 1'b0;
`endif

    assign bus.pin_oe   = r_pin_oe;
    assign bus.pin_o    = r_pin_o;
    assign bus.din      = r_din;
    assign bus.din_rise = r_din_rise;
    assign bus.din_fall = r_din_fall;
    assign bus.busy     = (r_state == S_TO_OUT) || (r_state == S_TO_IN);

endmodule
`default_nettype wire

// File: tb/tb_bidir_pin_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bidir_pin_ctrl
// Description : Directed self-checking bench for bidir_pin_ctrl.
//               It uses SYNC_STAGES=2, DEBOUNCE_CYCLES=8 and TURN_CYCLES=4.
//               The pad is looped back unless contention is forced.
// Revision    : 1.0
// ============================================================================
module tb_bidir_pin_ctrl;

    logic clk48;
    logic rst_n;
    logic pin_ext;
    logic fight;
    int   vecs;
    int   miscompares;

    bidir_pin_ctrl_if bus ();

    // This models the pad: the driven level wins unless contention is forced.
    assign bus.pin_i = (bus.pin_oe && !fight) ? bus.pin_o : pin_ext;

    bidir_pin_ctrl #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8),
        .TURN_CYCLES     (4)
    ) dut (
        .clk48 (clk48),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk48 = 1'b0;
    always #5 clk48 = ~clk48;

    task automatic tick();
        @(posedge clk48);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        rst_n = 1'b1; bus.dir_req = 1'b0; bus.dout = 1'b0; pin_ext = 1'b0; fight = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        obs = {bus.pin_oe, bus.pin_o, bus.din, bus.din_rise, bus.din_fall, bus.busy, bus.collision};
        vecs++;
        if (obs !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 0000000", obs);
        end
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_dir_out();
        logic [1:0] obs, exp;
        bus.dir_req = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            obs = {bus.pin_oe, bus.busy};
            exp = {(k >= 7), (k >= 3 && k <= 6)};
            vecs++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL dir_out clk%0d {oe,busy}: got %b want %b", k, obs, exp);
            end
        end
        bus.dout = 1'b1;
        vecs++;
        if (bus.pin_o !== 1'b0) begin
            miscompares++;
            $display("FAIL pin_o_latency: got %b want 0", bus.pin_o);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            vecs++;
            if (bus.pin_o !== bus.dout) begin
                miscompares++;
                $display("FAIL pin_o_follow step%0d: got %b want %b", k, bus.pin_o, bus.dout);
            end
            bus.dout = ~bus.dout;
        end
        bus.dout = 1'b1;
        tick();
    endtask

    task automatic test_dir_in();
        logic [2:0] obs, exp;
        bus.dir_req = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            obs = {bus.pin_oe, bus.pin_o, bus.busy};
            exp = {(k < 3), (k < 3), (k >= 3 && k <= 6)};
            vecs++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL dir_in clk%0d {oe,o,busy}: got %b want %b", k, obs, exp);
            end
        end
        bus.dout = 1'b0;
    endtask

    task automatic test_debounce();
        logic [2:0] obs, exp;
        int         bad;
        // A glitch of 5 or 7 cycles never reaches din.
        for (int g = 5; g <= 7; g += 2) begin
            bad = 0;
            pin_ext = 1'b1;
            repeat (g) begin
                tick();
                if (bus.din !== 1'b0 || bus.din_rise !== 1'b0) bad++;
            end
            pin_ext = 1'b0;
            repeat (12) begin
                tick();
                if (bus.din !== 1'b0 || bus.din_rise !== 1'b0) bad++;
            end
            vecs++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL glitch_%0d: got %0d bad cycles want 0", g, bad);
            end
        end
        pin_ext = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            obs = {bus.din, bus.din_rise, bus.din_fall};
            exp = {(k >= 10), (k == 10), 1'b0};
            if (k >= 9) begin
                vecs++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL rise clk%0d {din,rise,fall}: got %b want %b", k, obs, exp);
                end
            end
        end
        pin_ext = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            obs = {bus.din, bus.din_rise, bus.din_fall};
            exp = {(k < 10), 1'b0, (k == 10)};
            if (k >= 9) begin
                vecs++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL fall clk%0d {din,rise,fall}: got %b want %b", k, obs, exp);
                end
            end
        end
    endtask

    task automatic test_abort();
        int oe_cnt;
        int busy_cnt;
        oe_cnt = 0; busy_cnt = 0;
        bus.dir_req = 1'b1;
        tick();
        bus.dir_req = 1'b0;
        if (bus.busy === 1'b1) busy_cnt++;
        for (int k = 2; k <= 12; k++) begin
            tick();
            if (bus.pin_oe !== 1'b0) oe_cnt++;
            if (bus.busy === 1'b1) busy_cnt++;
        end
        vecs++;
        if (oe_cnt != 0) begin
            miscompares++;
            $display("FAIL abort_oe: got %0d cycles with oe want 0", oe_cnt);
        end
        vecs++;
        if (busy_cnt != 1) begin
            miscompares++;
            $display("FAIL abort_busy: got %0d busy cycles want 1", busy_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] obs;
        bus.dir_req = 1'b1;
        bus.dout    = 1'b1;
        repeat (8) tick();
        vecs++;
        if ({bus.pin_oe, bus.pin_o} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_pre_out {oe,o}: got %b want 11", {bus.pin_oe, bus.pin_o});
        end
        #3 rst_n = 1'b0;
        #1;
        vecs++;
        if (bus.pin_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_async_oe: got %b want 0", bus.pin_oe);
        end
        bus.dir_req = 1'b0;
        bus.dout    = 1'b0;
        tick();
        obs = {bus.pin_oe, bus.pin_o, bus.din, bus.din_rise, bus.din_fall, bus.busy, bus.collision};
        vecs++;
        if (obs !== 7'b0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %b want 0000000", obs);
        end
        rst_n = 1'b1;
        repeat (8) tick();
        vecs++;
        if ({bus.pin_oe, bus.busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL post_reset_idle {oe,busy}: got %b want 00", {bus.pin_oe, bus.busy});
        end
    endtask

    task automatic test_collision();
        logic [2:0] obs, exp;
        bus.dout    = 1'b1;
        fight       = 1'b1;
        pin_ext     = 1'b0;
        bus.dir_req = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            obs = {bus.pin_oe, bus.busy, bus.collision};
`ifdef COLLISION_DETECT_EN
            exp = {(k >= 7 && k <= 10), (k >= 3 && k <= 6) || (k == 11), (k == 11)};
`else
            exp = {(k >= 7), (k >= 3 && k <= 6), 1'b0};
`endif
            if (k >= 10) begin
                vecs++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL collision clk%0d {oe,busy,coll}: got %b want %b", k, obs, exp);
                end
            end
        end
`ifdef COLLISION_DETECT_EN
        repeat (10) tick();
        vecs++;
        if ({bus.pin_oe, bus.busy, bus.collision} !== 3'b001) begin
            miscompares++;
            $display("FAIL collision_hold {oe,busy,coll}: got %b want 001",
                     {bus.pin_oe, bus.busy, bus.collision});
        end
        bus.dir_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            vecs++;
            if (bus.collision !== (k < 3)) begin
                miscompares++;
                $display("FAIL collision_clear clk%0d: got %b want %b", k, bus.collision, (k < 3));
            end
        end
`else
        bus.dir_req = 1'b0;
        repeat (10) tick();
        vecs++;
        if ({bus.pin_oe, bus.collision} !== 2'b00) begin
            miscompares++;
            $display("FAIL collision_off_idle {oe,coll}: got %b want 00", {bus.pin_oe, bus.collision});
        end
`endif
        fight = 1'b0;
    endtask

    initial begin
        vecs        = 0;
        miscompares = 0;
        test_reset();
        test_dir_out();
        test_dir_in();
        test_debounce();
        test_abort();
        test_reset_mid();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
